// File: rtl/uart_txrx_if.sv
// Host-side and serial-pin signals of the full-duplex UART, bundled so the
// block and its user connect through one port.
interface uart_txrx_if;
  logic       i_tx_byte_rdy;
  logic [7:0] i_tx_byte;
  logic       o_tx_active;
  logic       o_tx_serial;
  logic       o_tx_done;
  logic       i_rx;
  logic       o_rx_byte_rdy;
  logic [7:0] o_rx_byte;

  modport slave (
    input  i_tx_byte_rdy, i_tx_byte, i_rx,
    output o_tx_active, o_tx_serial, o_tx_done, o_rx_byte_rdy, o_rx_byte
  );

  modport master (
    output i_tx_byte_rdy, i_tx_byte, i_rx,
    input  o_tx_active, o_tx_serial, o_tx_done, o_rx_byte_rdy, o_rx_byte
  );
endinterface

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one
// clock and a synchronous active-high reset. Baud set by CLKS_PER_BIT.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic  i_clk,
  input  logic  i_rst,
  uart_txrx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP} tx_state_e;
  // RX_HOLD is the tail of a bad stop bit: wait for the line to go high again.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_e;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_data_q;
  logic          tx_serial_q, tx_active_q, tx_done_q;

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q, rx_byte_q;
  logic          rx_rdy_q;
  logic          rx_meta_q, rx_sync_q;

  assign bus.o_tx_serial   = tx_serial_q;
  assign bus.o_tx_active   = tx_active_q;
  assign bus.o_tx_done     = tx_done_q;
  assign bus.o_rx_byte_rdy = rx_rdy_q;
  assign bus.o_rx_byte     = rx_byte_q;

  // Transmit FSM: each of start/data/stop holds the line for CLKS_PER_BIT cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_serial_q <= 1'b1;
          tx_active_q <= 1'b0;
          tx_done_q   <= 1'b0;
          tx_cnt_q    <= '0;
          tx_idx_q    <= '0;
          if (bus.i_tx_byte_rdy) begin
            tx_data_q   <= bus.i_tx_byte;
            tx_serial_q <= 1'b0;
            tx_active_q <= 1'b1;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q != BIT_LAST) tx_cnt_q <= tx_cnt_q + 1'b1;
          else begin
            tx_cnt_q    <= '0;
            tx_serial_q <= tx_data_q[0];
            tx_state_q  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q != BIT_LAST) tx_cnt_q <= tx_cnt_q + 1'b1;
          else begin
            tx_cnt_q <= '0;
            if (tx_idx_q != 3'd7) begin
              tx_idx_q    <= tx_idx_q + 3'd1;
              tx_serial_q <= tx_data_q[tx_idx_q + 3'd1];
            end else begin
              tx_idx_q    <= '0;
              tx_serial_q <= 1'b1;
              tx_state_q  <= TX_STOP;
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt_q != BIT_LAST) tx_cnt_q <= tx_cnt_q + 1'b1;
          else begin
            tx_cnt_q    <= '0;
            tx_done_q   <= 1'b1;
            tx_active_q <= 1'b0;
            tx_state_q  <= TX_CLEANUP;
          end
        end
        TX_CLEANUP: begin
          tx_done_q  <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous RX pin; idles high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM: re-check start at half bit, then sample every bit mid-period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_rdy_q <= 1'b0;
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          if (!rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q != HALF_LAST) rx_cnt_q <= rx_cnt_q + 1'b1;
          else begin
            rx_cnt_q   <= '0;
            // A line already back high is a glitch, not a start bit.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != BIT_LAST) rx_cnt_q <= rx_cnt_q + 1'b1;
          else begin
            rx_cnt_q             <= '0;
            rx_shift_q[rx_idx_q] <= rx_sync_q;
            rx_idx_q             <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != BIT_LAST) rx_cnt_q <= rx_cnt_q + 1'b1;
          else begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_rdy_q   <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_HOLD;
            end
          end
        end
        RX_HOLD: if (rx_sync_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: TX frame timing, table-driven RX vectors with a
// scoreboard of expected bytes, glitch/framing/reset corners, and a
// CLKS_PER_BIT=8 loopback instance.
module tb_uart_txrx;
  localparam int CPB    = 434;
  localparam int LB_CPB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_txrx_if dif ();
  uart_txrx_if lif ();

  uart_txrx #(.CLKS_PER_BIT(CPB))    u_dut (.i_clk(clk), .i_rst(rst), .bus(dif.slave));
  uart_txrx #(.CLKS_PER_BIT(LB_CPB)) u_lb  (.i_clk(clk), .i_rst(rst), .bus(lif.slave));

  assign lif.i_rx = lif.o_tx_serial;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors: record pulses seen on the opposite edge.
  int         rx_pulses = 0, rx_last_cyc = 0, tx_dones = 0, tx_last_done = 0, lb_pulses = 0;
  logic [7:0] rx_last_byte = 8'h00;
  logic [7:0] lb_got [4];
  always @(negedge clk) begin
    if (dif.o_rx_byte_rdy) begin
      rx_pulses    <= rx_pulses + 1;
      rx_last_cyc  <= cyc;
      rx_last_byte <= dif.o_rx_byte;
    end
    if (dif.o_tx_done) begin
      tx_dones     <= tx_dones + 1;
      tx_last_done <= cyc;
    end
    if (lif.o_rx_byte_rdy) begin
      if (lb_pulses < 4) lb_got[lb_pulses] <= lif.o_rx_byte;
      lb_pulses <= lb_pulses + 1;
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic rx_bit(input logic v, input int n);
    dif.i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rx_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) rx_bit(d[i], CPB);
    rx_bit(stop, CPB);
    dif.i_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch_first;
    logic       exp_rdy;
    logic [7:0] exp_byte;
  } rxv_t;

  rxv_t       vecs [4];
  logic [7:0] rx_exp_q[$];
  logic [7:0] lb_exp_q[$];
  logic [7:0] lb_bytes [4];

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0, s0, d0, n;
    logic [9:0] fr;
    logic [7:0] expb;

    vecs[0] = '{8'h3F, 1'b1, 1'b0, 1'b1, 8'h3F};
    vecs[1] = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h3F};
    vecs[2] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h34};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81};
    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h55; lb_bytes[3] = 8'hA5;

    rst = 1'b1;
    dif.i_tx_byte_rdy = 1'b0; dif.i_tx_byte = 8'h00; dif.i_rx = 1'b1;
    lif.i_tx_byte_rdy = 1'b0; lif.i_tx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_serial", dif.o_tx_serial, 1);
    check("rst_tx_active", dif.o_tx_active, 0);
    check("rst_tx_done", dif.o_tx_done, 0);
    check("rst_rx_rdy", dif.o_rx_byte_rdy, 0);
    check("rst_rx_byte", dif.o_rx_byte, 8'h00);
    rst = 1'b0;

    // TX 8'hAB: line levels mid-bit, mid-frame request/byte change ignored.
    @(posedge clk); #1;
    dif.i_tx_byte = 8'hAB; dif.i_tx_byte_rdy = 1'b1;
    @(posedge clk); #1;
    dif.i_tx_byte_rdy = 1'b0;
    s0 = cyc; d0 = tx_dones;
    fr = {1'b1, 8'hAB, 1'b0};
    for (int i = 0; i < 10; i++) begin
      at_cyc(s0 + i * CPB + CPB / 2);
      check($sformatf("tx_bit%0d", i), dif.o_tx_serial, fr[i]);
      check($sformatf("tx_active%0d", i), dif.o_tx_active, 1);
      if (i == 3) begin
        @(posedge clk); #1;
        dif.i_tx_byte = 8'h00; dif.i_tx_byte_rdy = 1'b1;
        @(posedge clk); #1;
        dif.i_tx_byte_rdy = 1'b0;
      end
    end
    at_cyc(s0 + 10 * CPB - 1);
    check("tx_active_last", dif.o_tx_active, 1);
    at_cyc(s0 + 10 * CPB);
    check("tx_done_pulse", dif.o_tx_done, 1);
    check("tx_active_cleanup", dif.o_tx_active, 0);
    at_cyc(s0 + 10 * CPB + 3);
    check("tx_done_count", tx_dones - d0, 1);
    check("tx_done_cycle", tx_last_done, s0 + 10 * CPB);
    check("tx_idle_line", dif.o_tx_serial, 1);

    // RX vectors; expected bytes go on the scoreboard as frames are driven.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      if (vecs[v].glitch_first) begin
        p0 = rx_pulses;
        rx_bit(1'b0, CPB / 4);
        rx_bit(1'b1, 2 * CPB);
        check("glitch_no_rdy", rx_pulses - p0, 0);
        check("glitch_byte_held", dif.o_rx_byte, 8'h34);
      end
      p0 = rx_pulses; c0 = cyc;
      if (vecs[v].stop) rx_exp_q.push_back(vecs[v].data);
      rx_frame(vecs[v].data, vecs[v].stop);
      repeat (CPB) @(posedge clk);
      #1;
      check($sformatf("rx%0d_pulses", v), rx_pulses - p0, vecs[v].exp_rdy);
      if (vecs[v].exp_rdy && rx_exp_q.size() > 0) begin
        expb = rx_exp_q.pop_front();
        check($sformatf("rx%0d_data", v), rx_last_byte, expb);
        check($sformatf("rx%0d_rdy_cycle", v), rx_last_cyc, c0 + 3 + CPB / 2 + 9 * CPB);
      end
      check($sformatf("rx%0d_byte_held", v), dif.o_rx_byte, vecs[v].exp_byte);
    end
    check("rx_scoreboard_empty", rx_exp_q.size(), 0);

    // Loopback at 8 clocks/bit, requests issued as soon as TX frees up.
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (lif.o_tx_active && n < 200) begin @(posedge clk); #1; n++; end
      lif.i_tx_byte = lb_bytes[b]; lif.i_tx_byte_rdy = 1'b1;
      lb_exp_q.push_back(lb_bytes[b]);
      n = 0;
      while (!lif.o_tx_active && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) check("lb_accept_timeout", n, 0);
      lif.i_tx_byte_rdy = 1'b0;
    end
    repeat (12 * LB_CPB + 10) @(posedge clk);
    #1;
    check("lb_pulses", lb_pulses, 4);
    for (int b = 0; b < 4; b++) begin
      expb = lb_exp_q.pop_front();
      check($sformatf("lb_byte%0d", b), lb_got[b], expb);
    end

    // Reset mid-TX-frame: line high at once, no done pulse afterwards.
    @(posedge clk); #1;
    dif.i_tx_byte = 8'hF0; dif.i_tx_byte_rdy = 1'b1;
    @(posedge clk); #1;
    dif.i_tx_byte_rdy = 1'b0;
    repeat (2 * CPB + 10) @(posedge clk);
    #1;
    check("pre_rst_active", dif.o_tx_active, 1);
    d0 = tx_dones;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx_serial", dif.o_tx_serial, 1);
    check("mid_rst_tx_active", dif.o_tx_active, 0);
    check("mid_rst_rx_byte", dif.o_rx_byte, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (11 * CPB) @(posedge clk);
    #1;
    check("post_rst_no_done", tx_dones - d0, 0);
    check("post_rst_line", dif.o_tx_serial, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
